mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access controller feeding the MEM/WB pipeline register. Takes a load/store from EX/MEM, runs a req/ack transaction against a variable-latency data memory, and freezes the pipeline with `stall_o` until the access completes. The load result is presented on `memData_o` for MEM/WB to capture in the cycle where the stall drops.

## Interface
- `DATA_W`, default 32: data and address width.
- `TIMEOUT`, default 255: maximum BUSY cycles waiting for `memAck_i` before abort; minimum 1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `memRead_i`  in  1  load request from EX/MEM.
- `memWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  DATA_W  byte address (ALU result).
- `wrData_i`  in  DATA_W  store data.
- `memReq_o`  out  1  memory request; held until ack.
- `memWe_o`  out  1  1 = write transaction.
- `memAddr_o`  out  DATA_W  memory address.
- `memWdata_o`  out  DATA_W  memory write data.
- `memAck_i`  in  1  one-cycle completion strobe from memory.
- `memRdata_i`  in  DATA_W  read data, valid with `memAck_i`.
- `memData_o`  out  DATA_W  load result to MEM/WB.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert no bubble.
- `err_o`  out  1  sticky timeout flag.
- `misalign_o`  out  1  misaligned-access pulse (see Configuration).

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, `memReq_o`=0, `memWe_o`=0, `memAddr_o`=0, `memWdata_o`=0, `memData_o`=0, `err_o`=0, timeout count=0.
- Access = `memRead_i | memWrite_i`. If both are set, treat it as a write.
- IDLE with access: go to BUSY. Register `memAddr_o`/`memWdata_o`/`memWe_o` from the inputs, set `memReq_o`=1, clear the count. IDLE without access: stay.
- BUSY: hold `memReq_o` and all request fields stable. On `memAck_i`:
  - Drop `memReq_o` and go to DONE.
  - Load: `memData_o` <= `memRdata_i`. Store: `memData_o` <= 0.
- BUSY without ack: increment the count. When the count reaches `TIMEOUT`:
  - Drop `memReq_o`, set `err_o`=1 (held until reset), `memData_o` <= 0, go to DONE.
  - A late `memAck_i` in IDLE/DONE is ignored.
- DONE: always go to IDLE the next cycle. Never re-issue from DONE, even if access is asserted.
- `stall_o` is combinational: 1 when (IDLE and access) or BUSY; 0 in DONE.
- `memAck_i` outside BUSY: ignored, no state change.
- Reset asserted mid-transaction: return to IDLE immediately with all outputs at reset values. Memory must tolerate a dropped request.

## Timing
- `stall_o` rises in the same cycle the access appears in EX/MEM (cycle 0).
- `memReq_o` is high from cycle 1.
- Ack in cycle k≥1 gives DONE in cycle k+1. `memData_o` is valid and `stall_o`=0 in cycle k+1, and MEM/WB captures at the end of that cycle.
- Zero-wait memory (ack in cycle 1): 2 stall cycles per access.
- Back-to-back accesses: next access detected in IDLE at cycle k+2, so at least 1 cycle of `stall_o`=0 between accesses.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - In IDLE, an access with `addr_i[1:0]`≠0 issues no request and raises no stall.
  - `misalign_o`=1 combinationally for that cycle.
  - `memData_o` <= 0 at the cycle end.
- `MEM_MISALIGN_CHECK_EN` undefined:
  - `misalign_o` tied 0.
  - `memAddr_o[1:0]` forced to 0; the access proceeds normally.

## Structure
- Package `mem_stage_pkg`: the state enum (IDLE/BUSY/DONE) and the default `DATA_W`/`TIMEOUT` constants.
- One sub-module, `mem_timeout_ctr`: clear/enable inputs, `expired` output, width $clog2(TIMEOUT+1).

## Test plan
- Load with ack in cycle 1, `addr_i`=0x10, `memRdata_i`=0xDEADBEEF -> `stall_o` high in cycles 0–1; `memData_o`=0xDEADBEEF and `stall_o`=0 in cycle 2.
- Store with ack after 5 cycles, `wrData_i`=0x1234 -> `memWe_o`=1, `memWdata_o`=0x1234 stable for 5 cycles; 6 stall cycles; `memData_o`=0.
- `memRead_i`=`memWrite_i`=1 -> `memWe_o`=1.
- Never ack, `TIMEOUT`=4 -> `memReq_o` drops after 4 BUSY cycles; `err_o`=1 and stays 1; `memData_o`=0; a late ack changes nothing.
- Reset pulsed in BUSY -> `memReq_o`, `stall_o` and `memData_o` are 0 before the next edge; state IDLE.
- With `MEM_MISALIGN_CHECK_EN`, load at 0x13 -> `misalign_o`=1 for one cycle, `stall_o`=0, `memReq_o` never rises. Without the macro -> `memAddr_o`=0x10.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and defaults for the MEM-stage data-memory access controller.
//   mem_state_e  : controller state (IDLE / BUSY / DONE), also exported on the
//                  controller's debug state output.
//   DEF_DATA_W   : default data/address width.
//   DEF_TIMEOUT  : default number of BUSY cycles to wait for an ack.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
// Counts BUSY cycles spent waiting for the memory acknowledge.
//   clk_i     : clock
//   rst_i     : asynchronous active-low reset (count -> 0)
//   clear_i   : synchronous clear, has priority over enable_i
//   enable_i  : count this cycle (BUSY and no ack)
//   expired_o : this cycle's increment makes the count reach TIMEOUT
// -----------------------------------------------------------------------------
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flagged one cycle early so the controller can leave BUSY on the very
    // cycle the count reaches TIMEOUT.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Turns a load/store held in EX/MEM
// into one req/ack transaction and stalls the pipeline until it completes.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned accesses are rejected in IDLE (misalign_o pulse,
//               no request, no stall, memData_o cleared).
//   undefined : misalign_o tied low, address bits [1:0] forced to zero.
//
// Ports
//   clk_i, rst_i               : clock, asynchronous active-low reset
//   memRead_i, memWrite_i      : load / store request (both set = store)
//   addr_i, wrData_i           : byte address, store data
//   memReq_o, memWe_o          : memory request, write enable
//   memAddr_o, memWdata_o      : memory address, write data
//   memAck_i, memRdata_i       : one-cycle completion strobe, read data
//   memData_o                  : load result for MEM/WB
//   stall_o                    : pipeline freeze (combinational)
//   err_o                      : sticky timeout flag
//   misalign_o                 : misaligned-access pulse
//   state_o                    : current controller state (debug)
//
// Memory handshake: memReq_o rises in the cycle after the access is accepted
// and stays high, with memWe_o/memAddr_o/memWdata_o frozen, until the cycle
// after memAck_i is seen high (or the wait times out). memAck_i is a single
// cycle strobe qualifying memRdata_i and is ignored whenever the controller is
// not in BUSY. The request may be withdrawn without an ack on timeout/reset.
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wrData_i,
    output logic              memReq_o,
    output logic              memWe_o,
    output logic [DATA_W-1:0] memAddr_o,
    output logic [DATA_W-1:0] memWdata_o,
    input  logic              memAck_i,
    input  logic [DATA_W-1:0] memRdata_i,
    output logic [DATA_W-1:0] memData_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              misalign_o,
    output mem_state_e        state_o
);

    mem_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic access;
    logic mis;
    logic expired;

    assign access = memRead_i | memWrite_i;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis = (state_q == IDLE) && access && (addr_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == IDLE),
        .enable_i  ((state_q == BUSY) && !memAck_i),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mis) begin
                        data_q <= '0;
                    end else if (access) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= memWrite_i;
                        // Word-aligned address; with the misalignment check
                        // enabled only aligned addresses get here anyway.
                        addr_q  <= addr_i & ~DATA_W'(3);
                        wdata_q <= wrData_i;
                    end
                end
                BUSY: begin
                    // An ack on the expiring cycle still completes normally.
                    if (memAck_i) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        data_q  <= we_q ? '0 : memRdata_i;
                    end else if (expired) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        data_q  <= '0;
                    end
                end
                DONE: begin
                    // EX/MEM still holds the finished access here; never re-issue.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o    = ((state_q == IDLE) && access && !mis) || (state_q == BUSY);
    assign misalign_o = mis;
    assign memReq_o   = req_q;
    assign memWe_o    = we_q;
    assign memAddr_o  = addr_q;
    assign memWdata_o = wdata_q;
    assign memData_o  = data_q;
    assign err_o      = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Randomized bench for mem_access_unit. A driver presents EX/MEM accesses and
// pushes the expected outcome of each into exp_q; a variable-latency memory
// responder answers requests; a monitor pops and compares whenever an access
// completes (stall falls) or is rejected (misalign pulse).
// TIMEOUT is 5 so that a 5-cycle store completes on the expiring cycle while
// anything slower times out.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mem_stage_pkg::*;

    localparam int DW = 32;
    localparam int TO = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          memRead_i = 1'b0;
    logic          memWrite_i = 1'b0;
    logic [DW-1:0] addr_i = '0;
    logic [DW-1:0] wrData_i = '0;
    logic          memReq_o;
    logic          memWe_o;
    logic [DW-1:0] memAddr_o;
    logic [DW-1:0] memWdata_o;
    logic          memAck_i = 1'b0;
    logic [DW-1:0] memRdata_i = '0;
    logic [DW-1:0] memData_o;
    logic          stall_o;
    logic          err_o;
    logic          misalign_o;
    mem_state_e    state_o;

    mem_access_unit #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .memRead_i  (memRead_i),
        .memWrite_i (memWrite_i),
        .addr_i     (addr_i),
        .wrData_i   (wrData_i),
        .memReq_o   (memReq_o),
        .memWe_o    (memWe_o),
        .memAddr_o  (memAddr_o),
        .memWdata_o (memWdata_o),
        .memAck_i   (memAck_i),
        .memRdata_i (memRdata_i),
        .memData_o  (memData_o),
        .stall_o    (stall_o),
        .err_o      (err_o),
        .misalign_o (misalign_o),
        .state_o    (state_o)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk_i = ~clk_i;

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic          mis;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        int            stall;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: outcome of one access from the behavioural rules.
    // lat = cycle (counted from the first request cycle) in which memory acks;
    // 0 means memory never acks.
    function automatic exp_t model(input logic wr, input logic [DW-1:0] addr,
                                   input logic [DW-1:0] wdata, input int lat,
                                   input logic [DW-1:0] rdata);
        exp_t e;
        bit   timed_out;
        timed_out = (lat == 0) || (lat > TO);
`ifdef MEM_MISALIGN_CHECK_EN
        e.mis = (addr % 4) != 0;
`else
        e.mis = 1'b0;
`endif
        e.we    = wr;
        e.addr  = (addr / 4) * 4;
        e.wdata = wdata;
        e.to    = timed_out && !e.mis;
        e.data  = (e.mis || timed_out || wr) ? '0 : rdata;
        e.stall = e.mis ? 0 : (timed_out ? TO + 1 : lat + 1);
        return e;
    endfunction

    // ---------------------------------------------------------------- memory responder
    int            mem_lat = 1;
    logic [DW-1:0] mem_rdata = '0;
    int            mem_cnt = 0;

    always @(posedge clk_i) begin
        #1;
        memAck_i   = 1'b0;
        memRdata_i = $urandom;
        if (memReq_o) begin
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
                memAck_i   = 1'b1;
                memRdata_i = mem_rdata;
            end
        end else begin
            mem_cnt = 0;
            // Stray acks while no request is outstanding must be ignored.
            if ($urandom_range(0, 7) == 0) memAck_i = 1'b1;
        end
    end

    // ---------------------------------------------------------------- monitor
    logic          prev_stall = 1'b0;
    int            stall_cnt = 0;
    logic [DW-1:0] model_data = '0;
    logic          model_err = 1'b0;
    exp_t          mon_e;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            exp_q.delete();
            prev_stall = 1'b0;
            stall_cnt  = 0;
            model_data = '0;
            model_err  = 1'b0;
        end else begin
            if (stall_o) stall_cnt++;
            if (memReq_o) begin
                if (exp_q.size() == 0) begin
                    check("req_without_access", 32'(memReq_o), 32'(0));
                end else begin
                    check("req_addr", memAddr_o, exp_q[0].addr);
                    check("req_we", 32'(memWe_o), 32'(exp_q[0].we));
                    check("req_wdata", memWdata_o, exp_q[0].wdata);
                end
            end
            if (!stall_o && prev_stall) begin
                if (exp_q.size() == 0) begin
                    check("done_without_access", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_kind_mis", 32'(0), 32'(mon_e.mis));
                    check("done_data", memData_o, mon_e.data);
                    check("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
                    check("done_req_low", 32'(memReq_o), 32'(0));
                    model_data = mon_e.data;
                    model_err  = model_err | mon_e.to;
                end
                stall_cnt = 0;
            end
            check("data_hold", memData_o, model_data);
            check("err_flag", 32'(err_o), 32'(model_err));
            if (misalign_o) begin
                if (exp_q.size() == 0) begin
                    check("misalign_without_access", 32'(1), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("misalign_expected", 32'(mon_e.mis), 32'(1));
                    check("misalign_stall", 32'(stall_o), 32'(0));
                    check("misalign_req", 32'(memReq_o), 32'(0));
                    model_data = '0;
                end
            end
            prev_stall = stall_o;
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic start(input logic rd, input logic wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
        exp_q.push_back(model(wr, addr, wdata, lat, rdata));
        mem_lat   = lat;
        mem_rdata = rdata;
        @(posedge clk_i);
        #1;
        memRead_i  = rd;
        memWrite_i = wr;
        addr_i     = addr;
        wrData_i   = wdata;
    endtask

    // EX/MEM holds the access while stall_o is high; wait for it to drop.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (stall_o && n < 40);
        if (stall_o) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: stall_o still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
        start(rd, wr, addr, wdata, lat, rdata);
        wait_done();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            memRead_i  = 1'b0;
            memWrite_i = 1'b0;
            addr_i     = $urandom;
            wrData_i   = $urandom;
        end
    endtask

    task automatic reset_mid();
        start(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i      = 1'b0;
        memRead_i  = 1'b0;
        memWrite_i = 1'b0;
        #1;
        check("rst_mid_req", 32'(memReq_o), 32'(0));
        check("rst_mid_stall", 32'(stall_o), 32'(0));
        check("rst_mid_data", memData_o, 32'h0);
        check("rst_mid_err", 32'(err_o), 32'(0));
        check("rst_mid_state", 32'(state_o), 32'(IDLE));
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        logic rd;
        logic wr;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 32'(memReq_o), 32'(0));
        check("rst_we", 32'(memWe_o), 32'(0));
        check("rst_addr", memAddr_o, 32'h0);
        check("rst_wdata", memWdata_o, 32'h0);
        check("rst_data", memData_o, 32'h0);
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_stall", 32'(stall_o), 32'(0));
        check("rst_state", 32'(state_o), 32'(IDLE));
        rst_i = 1'b1;
        idle(2);

        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);   // zero-wait load
        issue(1'b0, 1'b1, 32'h0000_0020, 32'h1234, 5, 32'h5555_AAAA); // ack on expiring cycle
        issue(1'b1, 1'b1, 32'h0000_0030, 32'hA5A5, 2, 32'h0BAD_F00D); // both set -> store
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);           // never acked
        idle(2);
        issue(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'hCAFE_F00D);   // misaligned load
        issue(1'b1, 1'b0, 32'h0000_0044, 32'h0, 3, 32'h1357_9BDF);
        reset_mid();
        idle(1);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(rd, wr, $urandom, $urandom, $urandom_range(0, TO + 2), $urandom);
        end
        idle(4);
        @(negedge clk_i);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
